alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multicycle command front-end for the 16-bit ALU datapath. It accepts ALU commands over a valid/ready handshake and fetches operands from an internal register file. It drives the ALU core with opcode, operands and carry-in, captures the result and zero/negative flags, writes the result back, and returns it over a response handshake. A side load port initialises registers.

## Interface
- WIDTH, 16, datapath width
- NREGS, 8, register-file depth (address width AW = clog2(NREGS))
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_opc  in  3  ALU opcode
- cmd_dst / cmd_srca / cmd_srcb  in  AW each  destination, operand-A, operand-B register indices
- ld_en  in  1  register-file load strobe
- ld_addr  in  AW  load index
- ld_data  in  WIDTH  load value
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  WIDTH  result W
- rsp_zer  out  1  W == 0
- rsp_neg  out  1  W[WIDTH-1]
- carry  out  1  current carry flag

## Operation
- FSM states: IDLE → READ → EXEC → RESP → IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch opc/dst/srca/srcb and go to READ. cmd_ready is 0 in every other state.
- READ: at end of cycle, register A=rf[srca], B=rf[srcb], C=carry. Go to EXEC.
- EXEC: compute W. At the end of the cycle:
  - load rsp_data/zer/neg
  - write rf[dst]=W
  - update carry
  - go to RESP.
- RESP: rsp_valid=1, outputs held stable until rsp_valid&rsp_ready, then go to IDLE.
- Opcodes, all arithmetic modulo 2^WIDTH:
  - 0: A+B+C
  - 1: 2A+B
  - 2: B+1
  - 3: floor(3B/4), using a WIDTH+2-bit intermediate
  - 4: A&B
  - 5: A|B
  - 6: ~B
  - 7: 0
- Carry: ops 0–2 set carry to bit WIDTH of the full-width sum. Ops 3–7 clear carry.
- Load port: write rf[ld_addr]=ld_data on any cycle with ld_en=1, in any state.
  - If the EXEC writeback hits the same address in the same cycle, the writeback wins.
  - A load landing on the same edge as the READ capture is not seen by that command.
- srca==srcb and dst==src are legal; operands are the pre-writeback values.

## Timing
- Reset values: state IDLE, all rf entries 0, carry 0, rsp_data 0, rsp_zer 0, rsp_neg 0, rsp_valid 0, cmd_ready 1 once released.
- Latency: command accepted at edge N, rsp_valid high from cycle N+2 (after the edges N+1, N+2).
- Throughput: at most one command per 4 cycles. With rsp_ready tied high: accept, READ, EXEC, RESP; next accept in the following IDLE.
- rsp_ready asserted while rsp_valid=0 is ignored.
- Reset asserted mid-operation aborts immediately:
  - no writeback, no response
  - carry and rf return to 0.
- Flags reflect the returned W only, never a stale value.

## Structure
- Package alu_pkg holds:
  - WIDTH default
  - opcode enum (OP_ADC, OP_A2B, OP_INC, OP_MUL34, OP_AND, OP_OR, OP_NOTB, OP_ZERO)
  - FSM state enum.
- Sub-module alu_core is combinational: A, B, C, opc in; W, cout, zer, neg out. The sequencer instantiates it once.
- Register file is inline (NREGS×WIDTH flops, async reset).

## Test plan
- Reset, then idle: rsp_valid=0, carry=0, cmd_ready=1, rsp_data=0.
- Load r1=0xFFFF, r2=0x0001; cmd opc0 dst3 a1 b2 → rsp_data=0x0000, zer=1, neg=0, carry=1, rsp_valid at N+2; rf[3]=0.
- Following cmd opc0 dst4 a2 b2 (carry=1 in) → 0x0003, carry=0. Then opc3 b=0x0010 → 0x000C, carry=0.
- opc6 on B=0x00FF → 0xFF00, neg=1. Hold rsp_ready=0 for 5 cycles: outputs stable, cmd_ready=0. Release: IDLE next cycle.
- Load to rf[dst] in the same cycle as the EXEC writeback → rf holds W.
- Assert rst during EXEC → rsp_valid stays 0, rf[dst] reads 0 after reset.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: datapath width, opcodes and FSM states.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_ADC   = 3'd0,  // A + B + C
    OP_A2B   = 3'd1,  // 2A + B
    OP_INC   = 3'd2,  // B + 1
    OP_MUL34 = 3'd3,  // floor(3B/4)
    OP_AND   = 3'd4,  // A & B
    OP_OR    = 3'd5,  // A | B
    OP_NOTB  = 3'd6,  // ~B
    OP_ZERO  = 3'd7   // 0
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, carry-out and zero/negative flags of the result.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  alu_op_e          opc,
  output logic [WIDTH-1:0] w,
  output logic             cout,
  output logic             zer,
  output logic             neg
);

  // Two guard bits: 2A+B and 3B both need WIDTH+2 bits before truncation.
  logic [WIDTH+1:0] full;

  // Opcode decode; only the additive ops report a carry out of bit WIDTH-1.
  always_comb begin
    full = '0;
    cout = 1'b0;
    case (opc)
      OP_ADC: begin
        full = {2'b00, a} + {2'b00, b} + {{(WIDTH + 1){1'b0}}, c};
        cout = full[WIDTH];
      end
      OP_A2B: begin
        full = {1'b0, a, 1'b0} + {2'b00, b};
        cout = full[WIDTH];
      end
      OP_INC: begin
        full = {2'b00, b} + (WIDTH + 2)'(1);
        cout = full[WIDTH];
      end
      OP_MUL34: full = ({2'b00, b} + {1'b0, b, 1'b0}) >> 2;
      OP_AND:   full = {2'b00, a & b};
      OP_OR:    full = {2'b00, a | b};
      OP_NOTB:  full = {2'b00, ~b};
      default:  full = '0;
    endcase
  end

  assign w   = full[WIDTH-1:0];
  assign zer = (w == '0);
  assign neg = w[WIDTH-1];

endmodule

// File: rtl/alu_sequencer.sv
// Multicycle ALU command front-end: IDLE -> READ -> EXEC -> RESP with an
// inline register file, a side load port and a persistent carry flag.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opc,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [AW-1:0]    cmd_srca,
  input  logic [AW-1:0]    cmd_srcb,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zer,
  output logic             rsp_neg,
  output logic             carry
);

  seq_state_e       state_q, state_d;
  alu_op_e          opc_q, opc_d;
  logic [AW-1:0]    dst_q, dst_d, srca_q, srca_d, srcb_q, srcb_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zer_q, rsp_zer_d, rsp_neg_q, rsp_neg_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] rf_d [NREGS];

  logic [WIDTH-1:0] alu_w;
  logic             alu_cout, alu_zer, alu_neg;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a    (a_q),
    .b    (b_q),
    .c    (c_q),
    .opc  (opc_q),
    .w    (alu_w),
    .cout (alu_cout),
    .zer  (alu_zer),
    .neg  (alu_neg)
  );

  // Next-state, operand capture, writeback and response register logic.
  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    dst_d       = dst_q;
    srca_d      = srca_q;
    srcb_d      = srcb_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    carry_d     = carry_q;
    rsp_data_d  = rsp_data_q;
    rsp_zer_d   = rsp_zer_q;
    rsp_neg_d   = rsp_neg_q;
    rsp_valid_d = rsp_valid_q;
    cmd_ready_d = cmd_ready_q;
    for (int i = 0; i < NREGS; i++) rf_d[i] = rf_q[i];

    // Load port first so a same-cycle EXEC writeback overrides it.
    if (ld_en) rf_d[ld_addr] = ld_data;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          opc_d       = alu_op_e'(cmd_opc);
          dst_d       = cmd_dst;
          srca_d      = cmd_srca;
          srcb_d      = cmd_srcb;
          cmd_ready_d = 1'b0;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        // Reads the current flops, so a load landing on this edge is not seen.
        a_d     = rf_q[srca_q];
        b_d     = rf_q[srcb_q];
        c_d     = carry_q;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        rsp_data_d    = alu_w;
        rsp_zer_d     = alu_zer;
        rsp_neg_d     = alu_neg;
        carry_d       = alu_cout;
        rf_d[dst_q]   = alu_w;
        rsp_valid_d   = 1'b1;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and register-file flops; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      opc_q       <= OP_ADC;
      dst_q       <= '0;
      srca_q      <= '0;
      srcb_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      carry_q     <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zer_q   <= 1'b0;
      rsp_neg_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      opc_q       <= opc_d;
      dst_q       <= dst_d;
      srca_q      <= srca_d;
      srcb_q      <= srcb_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      carry_q     <= carry_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zer_q   <= rsp_zer_d;
      rsp_neg_q   <= rsp_neg_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zer   = rsp_zer_q;
  assign rsp_neg   = rsp_neg_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed test-plan steps then randomized commands,
// checked against an arithmetic model of the register file and carry.
module tb_alu_sequencer;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_opc;
  logic [AW-1:0] cmd_dst, cmd_srca, cmd_srcb;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_zer, rsp_neg, carry;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_rf[N];
  int m_carry;

  alu_sequencer #(.WIDTH(W), .NREGS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_opc   (cmd_opc),
    .cmd_dst   (cmd_dst),
    .cmd_srca  (cmd_srca),
    .cmd_srcb  (cmd_srcb),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zer   (rsp_zer),
    .rsp_neg   (rsp_neg),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input int data);
    ld_en   = 1'b1;
    ld_addr = addr[AW-1:0];
    ld_data = data[W-1:0];
    step();
    ld_en = 1'b0;
    m_rf[addr] = data & 'hFFFF;
  endtask

  // mode 0: plain; 1: load srca on the READ-capture edge; 2: load dst on the EXEC edge.
  // early: rsp_ready value while no response is pending (must be ignored).
  task automatic run_cmd(input int opc, input int dst, input int sa, input int sb,
                         input int hold, input int mode, input int early);
    int a, b, c, full, w, cexp;
    a = m_rf[sa];
    b = m_rf[sb];
    c = m_carry;
    case (opc)
      0:       full = a + b + c;
      1:       full = 2 * a + b;
      2:       full = b + 1;
      3:       full = (3 * b) / 4;
      4:       full = a & b;
      5:       full = a | b;
      6:       full = (~b) & 'hFFFF;
      default: full = 0;
    endcase
    w    = full % 65536;
    cexp = (opc <= 2) ? ((full / 65536) % 2) : 0;

    chk("idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_opc   = opc[2:0];
    cmd_dst   = dst[AW-1:0];
    cmd_srca  = sa[AW-1:0];
    cmd_srcb  = sb[AW-1:0];
    rsp_ready = early[0];
    step();                                  // edge N: accepted
    cmd_valid = 1'b0;
    chk("busy_ready", cmd_ready, 0);
    chk("no_rsp_n0", rsp_valid, 0);
    if (mode == 1) begin
      ld_en   = 1'b1;
      ld_addr = sa[AW-1:0];
      ld_data = W'($urandom);
    end
    step();                                  // edge N+1: operand capture
    if (mode == 1) begin
      ld_en    = 1'b0;
      m_rf[sa] = int'(ld_data);
    end
    chk("no_rsp_n1", rsp_valid, 0);
    rsp_ready = (hold == 0);
    if (mode == 2) begin
      ld_en   = 1'b1;
      ld_addr = dst[AW-1:0];
      ld_data = W'($urandom);
    end
    step();                                  // edge N+2: result registered
    ld_en     = 1'b0;
    m_rf[dst] = w;
    m_carry   = cexp;
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, w);
      chk("rsp_zer", rsp_zer, (w == 0));
      chk("rsp_neg", rsp_neg, (w / 32768) % 2);
      chk("carry", carry, cexp);
      chk("resp_ready_low", cmd_ready, 0);
      if (i == hold) rsp_ready = 1'b1;
      step();
    end
    rsp_ready = 1'b0;
    chk("rsp_done", rsp_valid, 0);
    chk("back_idle", cmd_ready, 1);
    $display("cmd opc=%0d dst=%0d a=%0d b=%0d mode=%0d hold=%0d -> W=0x%04h C=%0d",
             opc, dst, sa, sb, mode, hold, w, cexp);
  endtask

  // Observe a register through the DUT: OR of a register with itself.
  task automatic peek(input int r);
    run_cmd(5, r, r, r, 0, 0, 0);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_opc   = '0;
    cmd_dst   = '0;
    cmd_srca  = '0;
    cmd_srcb  = '0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) m_rf[i] = 0;
    m_carry = 0;

    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_carry", carry, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_zer", rsp_zer, 0);
    chk("rst_rsp_neg", rsp_neg, 0);

    // Directed test-plan steps
    load(1, 'hFFFF);
    load(2, 'h0001);
    run_cmd(0, 3, 1, 2, 0, 0, 0);            // 0xFFFF+1 -> 0, carry 1
    run_cmd(0, 4, 2, 2, 0, 0, 0);            // 1+1+1 -> 3, carry 0
    load(5, 'h0010);
    run_cmd(3, 6, 0, 5, 0, 0, 0);            // 3*16/4 -> 0xC
    load(7, 'h00FF);
    run_cmd(6, 0, 0, 7, 5, 0, 0);            // ~0x00FF, held 5 cycles
    run_cmd(1, 5, 1, 2, 0, 2, 0);            // load to dst collides with writeback
    peek(5);
    peek(3);
    run_cmd(2, 2, 0, 1, 0, 1, 1);            // load on READ edge not seen; early rsp_ready

    // Reset during EXEC: no response, rf and carry cleared
    run_cmd(0, 3, 1, 1, 0, 0, 0);            // leaves carry set
    cmd_valid = 1'b1;
    cmd_opc   = 3'd0;
    cmd_dst   = 3'd6;
    cmd_srca  = 3'd1;
    cmd_srcb  = 3'd2;
    step();
    cmd_valid = 1'b0;
    step();                                  // now in EXEC
    rst = 1'b1;
    #1;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_carry", carry, 0);
    step();
    chk("abort_rsp_valid2", rsp_valid, 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) m_rf[i] = 0;
    m_carry = 0;
    step();
    chk("abort_rsp_valid3", rsp_valid, 0);
    peek(6);
    peek(1);

    // Randomized commands
    for (int i = 0; i < N; i++) load(i, int'($urandom_range(0, 65535)));
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0)
        load(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 65535)));
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, N - 1)),
              int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 1)));
    end
    for (int i = 0; i < N; i++) peek(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
